// File: rtl/masked_sbox_seq_ctrl.sv
// Sequencer for a pipelined 3-share masked AES S-box datapath.
// It accepts share triples together with one fresh randomness word per
// evaluation, slices the word per stage, drives the stage register enables,
// tracks in-flight valids and applies output backpressure. No share data
// passes through this block.
// Optional feature: define MASKED_SBOX_SEQ_GAP_EN to force at least one idle
// stage-0 cycle after every accept, so stage registers never take two triples
// back-to-back. This halves throughput.
module masked_sbox_seq_ctrl #(
  parameter int STAGES = 4,
  parameter int RND_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic                    i_rnd_valid,
  input  logic [STAGES*RND_W-1:0] i_rnd_data,
  output logic                    o_rnd_ready,
  input  logic                    i_flush,
  output logic                    o_dp_load,
  output logic [STAGES-1:0]       o_dp_stage_en,
  output logic [STAGES*RND_W-1:0] o_dp_rnd,
  output logic                    o_dp_clr,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_busy
);

  localparam int CW = $clog2(STAGES);
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]        r_state;
  logic [CW-1:0]     r_clr_cnt;
  logic [STAGES-1:0] r_v;

  logic w_run;
  logic w_stall;
  logic w_advance;
  logic w_slot;
  logic w_accept;
  logic w_gap_ok;

  assign w_run     = (r_state == S_RUN);
  assign w_stall   = r_v[STAGES-1] & ~i_out_ready;
  assign w_advance = ~w_stall;
  // A slot is only offered when a fresh mask word is present, so a triple
  // can never enter the datapath without its own randomness.
  assign w_slot    = w_run & i_rnd_valid & w_advance & w_gap_ok;
  assign w_accept  = w_slot & i_in_valid;

  assign o_in_ready  = w_slot;
  assign o_rnd_ready = w_slot;
  assign o_dp_load   = w_slot;
  assign o_dp_clr    = ~w_run;
  assign o_out_valid = r_v[STAGES-1];
  assign o_busy      = (|r_v) | ~w_run;

`ifdef MASKED_SBOX_SEQ_GAP_EN
  logic r_gap_ok;

  // Block the cycle right after an accept; reopen on the following one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_ok <= 1'b1;
    end else if (i_flush) begin
      r_gap_ok <= 1'b1;
    end else begin
      r_gap_ok <= ~w_accept;
    end
  end

  assign w_gap_ok = r_gap_ok;
`else
  assign w_gap_ok = 1'b1;
`endif

  // CLEAR holds the datapath in clear for STAGES cycles, then moves to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else if (i_flush) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      if (r_clr_cnt == CW'(STAGES - 1)) begin
        r_state   <= S_RUN;
        r_clr_cnt <= '0;
      end else begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  // Valid shift register: moves on advance, holds on output stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else if (i_flush) begin
      r_v <= '0;
    end else if (w_advance) begin
      r_v <= {r_v[STAGES-2:0], w_accept};
    end
  end

  // Stage 0 takes slice 0 straight from the PRNG word in the accept cycle.
  assign o_dp_stage_en[0]     = w_run ? w_accept : 1'b1;
  assign o_dp_rnd[RND_W-1:0]  = w_accept ? i_rnd_data[RND_W-1:0] : '0;

  // Stage gi uses slice gi, carried gi cycles alongside the valid bits.
  for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
    logic [RND_W-1:0] r_dl [gi];
    logic             w_en;

    // Per-slice delay chain; only the slice this stage will need is stored.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < gi; j++) r_dl[j] <= '0;
      end else if (i_flush) begin
        for (int j = 0; j < gi; j++) r_dl[j] <= '0;
      end else if (w_advance) begin
        r_dl[0] <= w_accept ? i_rnd_data[gi*RND_W +: RND_W] : '0;
        for (int j = 1; j < gi; j++) r_dl[j] <= r_dl[j-1];
      end
    end

    assign w_en = w_advance & r_v[gi-1];
    assign o_dp_stage_en[gi]           = w_run ? w_en : 1'b1;
    assign o_dp_rnd[gi*RND_W +: RND_W] = (w_run & w_en) ? r_dl[gi-1] : '0;
  end

endmodule

// File: tb/tb_masked_sbox_seq_ctrl.sv
// Testbench for masked_sbox_seq_ctrl. The reference model tracks each
// accepted evaluation as an item with a pipeline position and its mask word.
// It derives the expected handshakes, enables and randomness from those items.
module tb_masked_sbox_seq_ctrl;
  localparam int S  = 4;
  localparam int W  = 6;
  localparam int DW = S * W;
`ifdef MASKED_SBOX_SEQ_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, rnd_valid, flush, out_ready;
  logic [DW-1:0] rnd_data;
  logic          in_ready, rnd_ready, dp_load, dp_clr, out_valid, busy;
  logic [S-1:0]  dp_stage_en;
  logic [DW-1:0] dp_rnd;

  masked_sbox_seq_ctrl #(.STAGES(S), .RND_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_rnd_valid(rnd_valid), .i_rnd_data(rnd_data), .o_rnd_ready(rnd_ready),
    .i_flush(flush), .o_dp_load(dp_load), .o_dp_stage_en(dp_stage_en),
    .o_dp_rnd(dp_rnd), .o_dp_clr(dp_clr), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            pos;
    logic [DW-1:0] w;
  } item_t;

  item_t q[$];
  int    m_clr_left;
  bit    m_gap;

  int n_checks = 0;
  int n_pass   = 0;
  int obs_acc, obs_out, obs_clr, cyc;
  int acc_cyc, out_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset();
    q.delete();
    m_clr_left = S;
    m_gap      = 1'b1;
  endtask

  // One clock cycle: drive at negedge, compare against the model, then step
  // the model at the following posedge.
  task automatic run_cycle(input bit iv, input bit rv, input logic [DW-1:0] d,
                           input bit ordy, input bit fl);
    bit            run, has_last, stall, slot, acc;
    logic [S-1:0]  e_en;
    logic [DW-1:0] e_rnd;
    @(negedge clk);
    in_valid = iv; rnd_valid = rv; rnd_data = d; out_ready = ordy; flush = fl;
    #1;
    run      = (m_clr_left == 0);
    has_last = 1'b0;
    foreach (q[i]) if (q[i].pos == S - 1) has_last = 1'b1;
    stall = has_last & ~ordy;
    slot  = run & rv & ~stall & (GAP ? m_gap : 1'b1);
    acc   = slot & iv;
    e_en  = '0;
    e_rnd = '0;
    if (!run) begin
      e_en = '1;
    end else begin
      e_en[0] = acc;
      if (acc) e_rnd[W-1:0] = d[W-1:0];
      for (int k = 1; k < S; k++) begin
        foreach (q[i]) begin
          if (q[i].pos == k - 1 && !stall) begin
            e_en[k] = 1'b1;
            e_rnd[k*W +: W] = q[i].w[k*W +: W];
          end
        end
      end
    end
    chk("in_ready",  64'(in_ready),    64'(slot));
    chk("rnd_ready", 64'(rnd_ready),   64'(slot));
    chk("dp_load",   64'(dp_load),     64'(slot));
    chk("stage_en",  64'(dp_stage_en), 64'(e_en));
    chk("dp_rnd",    64'(dp_rnd),      64'(e_rnd));
    chk("dp_clr",    64'(dp_clr),      64'(!run));
    chk("out_valid", 64'(out_valid),   64'(has_last));
    chk("busy",      64'(busy),        64'((q.size() != 0) || !run));
    if (in_valid && in_ready) begin
      obs_acc++;
      if (acc_cyc < 0) acc_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      obs_out++;
      if (out_cyc < 0) out_cyc = cyc;
    end
    if (dp_clr) obs_clr++;
    $display("cyc %0d iv=%0b rv=%0b ordy=%0b fl=%0b acc=%0b en=%b ov=%0b clr=%0b",
             cyc, iv, rv, ordy, fl, in_valid && in_ready, dp_stage_en, out_valid, dp_clr);
    @(posedge clk);
    cyc++;
    if (fl) begin
      model_reset();
    end else begin
      if (!run) m_clr_left--;
      else if (!stall) begin
        foreach (q[i]) q[i].pos++;
        if (q.size() != 0 && q[0].pos == S) void'(q.pop_front());
        if (acc) q.push_back('{pos: 0, w: d});
      end
      m_gap = ~acc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, DW'($urandom), 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready",  64'(in_ready),    64'(0));
    chk("rst_rnd_ready", 64'(rnd_ready),   64'(0));
    chk("rst_dp_load",   64'(dp_load),     64'(0));
    chk("rst_dp_rnd",    64'(dp_rnd),      64'(0));
    chk("rst_dp_clr",    64'(dp_clr),      64'(1));
    chk("rst_out_valid", 64'(out_valid),   64'(0));
    chk("rst_busy",      64'(busy),        64'(1));
  endtask

  initial begin
    int o0, a0;
    rst_n = 1'b0; in_valid = 1'b1; rnd_valid = 1'b1; flush = 1'b0;
    out_ready = 1'b1; rnd_data = '0;
    cyc = 0; obs_acc = 0; obs_out = 0; obs_clr = 0;
    acc_cyc = -1; out_cyc = -1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs();

    // Reset release with in_valid held: four clear cycles, then ready.
    @(posedge clk); #1 rst_n = 1'b1;
    obs_clr = 0; obs_acc = 0;
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b1, DW'($urandom), 1'b1, 1'b0);
    chk("t1_clr_cycles", 64'(obs_clr), 64'(4));
    chk("t1_accepts",    64'(obs_acc), 64'(GAP ? 1 : 2));
    idle(8);

    // Single accept with a known mask word; latency to out_valid.
    acc_cyc = -1; out_cyc = -1;
    run_cycle(1'b1, 1'b1, 24'hABCDEF, 1'b1, 1'b0);
    idle(7);
    chk("t2_latency", 64'(out_cyc - acc_cyc), 64'(S));

    // Stream 8 triples with output backpressure in cycles 5..7.
    o0 = obs_out; a0 = obs_acc;
    for (int i = 0; i < 30; i++)
      run_cycle((obs_acc - a0) < 8, 1'b1, DW'($urandom), !(i >= 5 && i <= 7), 1'b0);
    chk("t3_accepts", 64'(obs_acc - a0), 64'(8));
    chk("t3_outputs", 64'(obs_out - o0), 64'(8));

    // Randomness availability toggling.
    idle(3);
    a0 = obs_acc;
    for (int i = 0; i < 4; i++) run_cycle(1'b1, (i % 2) == 0, DW'($urandom), 1'b1, 1'b0);
    chk("t4_accepts", 64'(obs_acc - a0), 64'(2));
    idle(8);

    // Flush with three evaluations in flight; nothing may emerge.
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b1, 1'b1, DW'($urandom), 1'b1, 1'b0);
      if (GAP) run_cycle(1'b0, 1'b1, DW'($urandom), 1'b1, 1'b0);
    end
    o0 = obs_out;
    run_cycle(1'b1, 1'b1, DW'($urandom), 1'b1, 1'b1);
    obs_clr = 0;
    idle(8);
    chk("t5_outputs",    64'(obs_out - o0), 64'(0));
    chk("t5_clr_cycles", 64'(obs_clr),      64'(4));

    // Continuous offer for 10 cycles.
    a0 = obs_acc;
    for (int i = 0; i < 10; i++) run_cycle(1'b1, 1'b1, DW'($urandom), 1'b1, 1'b0);
    chk("t6_accepts", 64'(obs_acc - a0), 64'(GAP ? 5 : 10));
    idle(8);

    // Asynchronous reset with evaluations in flight.
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, DW'($urandom), 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    model_reset();
    @(negedge clk); #1;
    check_reset_outputs();
    @(posedge clk); #1 rst_n = 1'b1;
    o0 = obs_out;
    idle(10);
    chk("rst_mid_outputs", 64'(obs_out - o0), 64'(0));

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      run_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, DW'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
